sifreleme_boru_kati: RTL
========================

Name: sifreleme_boru_kati

Overview:
- Two-stage pipeline wrapper around the combinational crypto/bit-manipulation unit in the X-instruction execute path.
- Upstream side takes one request per cycle from issue: control code, two operands and destination register.
- The operand register (S1) drives the combinational unit. Its result is captured in a result register (S2) and handed to writeback with a valid/ready handshake.
- Provides stall/back-pressure isolation and a clean flush point, so the unit's long combinational paths are cut from the rest of the core.

Parameters:
- VERI_BIT, 32, operand/result width.
- HEDEF_BIT, 5, destination register index width.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- bosalt_i  in  1  synchronous flush (branch mispredict/exception).
- istek_gecerli_i  in  1  issue presents a valid request.
- istek_hazir_o  out  1  block can accept a request this cycle.
- kontrol_i  in  3  SIFRELEME_* operation code.
- deger1_i  in  VERI_BIT  operand 1.
- deger2_i  in  VERI_BIT  operand 2.
- hedef_i  in  HEDEF_BIT  destination register.
- birim_kontrol_o  out  3  S1 control to the unit.
- birim_deger1_o  out  VERI_BIT  S1 operand 1 to the unit.
- birim_deger2_o  out  VERI_BIT  S1 operand 2 to the unit.
- birim_sonuc_i  in  VERI_BIT  combinational result from the unit.
- sonuc_gecerli_o  out  1  S2 holds a valid result.
- sonuc_hazir_i  in  1  writeback accepts the result.
- sonuc_o  out  VERI_BIT  S2 result.
- sonuc_hedef_o  out  HEDEF_BIT  S2 destination.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - s1_gecerli=0 and s2_gecerli=0.
  - All S1/S2 data registers=0, so birim_*_o=0, sonuc_o=0, sonuc_hedef_o=0, sonuc_gecerli_o=0.
  - Release is synchronous to clk_i; the first accept is possible on the first edge after release.
- Handshakes:
  - Upstream transfer when istek_gecerli_i & istek_hazir_o.
  - Downstream transfer when sonuc_gecerli_o & sonuc_hazir_i.
- Advance logic:
  - s2_bos = !s2_gecerli | sonuc_hazir_i.
  - s1_ilerle = s1_gecerli & s2_bos.
  - istek_hazir_o = (!s1_gecerli | s2_bos) & !bosalt_i.
  - istek_hazir_o is combinational from sonuc_hazir_i; no combinational path from istek_gecerli_i to istek_hazir_o.
- Data movement:
  - s1_ilerle: S2 <= {birim_sonuc_i, S1.hedef}; s2_gecerli <= 1.
  - S2 drained with no S1 advance: s2_gecerli <= 0; S2 data holds its last value.
  - Upstream transfer: S1 <= {kontrol_i, deger1_i, deger2_i, hedef_i}; s1_gecerli <= 1.
  - S1 advanced with no new transfer: s1_gecerli <= 0.
  - Stalled stage: data registers hold, and S1 keeps driving the unit unchanged.
- Latency: accept on edge N gives sonuc_gecerli_o=1 after edge N+1.
- Throughput: 1 op/cycle when sonuc_hazir_i is held 1.
- Full pipe: S1 and S2 valid with sonuc_hazir_i=0 gives istek_hazir_o=0. Nothing is overwritten or dropped.
- Simultaneous drain + advance + accept in one cycle is legal; all three happen.
- Flush: bosalt_i=1 clears s1_gecerli and s2_gecerli at the next edge.
  - An istek in the same cycle is refused (istek_hazir_o=0).
  - A result accepted downstream in that same cycle counts as delivered.
- Control codes are not checked here. Codes outside SIFRELEME_* pass through and return the unit's output (0).
- hedef_i=0 is delivered normally; writeback discards it.
- Reset mid-operation discards all in-flight ops immediately.

Optional Feature:
- Macro: SIFRELEME_SAYAC_EN.
- Defined:
  - Adds output islem_sayisi_o [31:0], reset 0.
  - Increments by 1 on every downstream transfer and wraps 0xFFFF_FFFF to 0.
  - Not affected by bosalt_i.
- Undefined: the port and counter do not exist. Behaviour is otherwise identical.

Decomposition:
- Operation codes SIFRELEME_HMDST/PKG/RVRS/SLADD/CNTZ/CNTP stay in tanimlamalar.vh; no new constants.
- One natural sub-module: boru_yazmaci, a valid-tagged pipeline register with load/clear/hold. It is instantiated twice, for S1 and S2.

Test Plan:
- Pipe flow, bench wraps block + crypto unit:
  - Reset, then CNTP with deger1=0x0000_00FF, hedef=3, sonuc_hazir_i=1.
  - Required: sonuc_gecerli_o after 2 edges, sonuc_o=8, sonuc_hedef_o=3.
- Back-to-back, sonuc_hazir_i=1:
  - HMDST(0xFFFF_0000, 0x0000_0000), then CNTZ(0x0000_0001).
  - Required: results 16 then 31 on consecutive cycles.
- Stall:
  - sonuc_hazir_i=0, issue 3 requests.
  - Required: first two accepted, istek_hazir_o=0 on the third. Then raise sonuc_hazir_i: all three delivered in order, none lost or duplicated.
- Flush:
  - With S1 and S2 full, pulse bosalt_i with istek_gecerli_i=1.
  - Required: next cycle sonuc_gecerli_o=0, nothing accepted, pipe empty.
- Async reset:
  - Drop rst_i mid-cycle with both stages valid.
  - Required: sonuc_gecerli_o=0 and sonuc_o=0 before the next clock edge.
- With SIFRELEME_SAYAC_EN:
  - 5 delivered ops plus 1 flushed op: islem_sayisi_o=5.
  - Preload 0xFFFF_FFFF via force, deliver 1 op: islem_sayisi_o=0.

Source files
------------

// File: rtl/sifreleme_boru_kati_pkg.sv
// ============================================================================
// Module      : sifreleme_boru_kati_pkg
// Description : Shared types and helpers for the crypto-unit pipeline wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sifreleme_boru_kati_pkg;

  localparam int KONTROL_BIT = 3;
  localparam int SAYAC_BIT   = 32;

  typedef logic [KONTROL_BIT-1:0] kontrol_t;

  function automatic logic [SAYAC_BIT-1:0] sayac_sonraki(input logic [SAYAC_BIT-1:0] sayi);
    return sayi + SAYAC_BIT'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sifreleme_boru_kati_boru_yazmaci.sv
// ============================================================================
// Module      : boru_yazmaci
// Description : Valid-tagged pipeline register with load / clear / hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boru_yazmaci
  import sifreleme_boru_kati_pkg::*;
#(
  parameter int GENISLIK = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                yukle_i,
  input  logic                temizle_i,
  input  logic [GENISLIK-1:0] veri_i,
  output logic                gecerli_o,
  output logic [GENISLIK-1:0] veri_o
);

  logic                gecerli_q, gecerli_d;
  logic [GENISLIK-1:0] veri_q, veri_d;

  // Load wins over clear so a stage can empty and refill on the same edge.
  always_comb begin
    gecerli_d = gecerli_q;
    veri_d    = veri_q;
    if (yukle_i) begin
      gecerli_d = 1'b1;
      veri_d    = veri_i;
    end else if (temizle_i) begin
      gecerli_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      gecerli_q <= 1'b0;
      veri_q    <= '0;
    end else begin
      gecerli_q <= gecerli_d;
      veri_q    <= veri_d;
    end
  end

  assign gecerli_o = gecerli_q;
  assign veri_o    = veri_q;

endmodule

`default_nettype wire

// File: rtl/sifreleme_boru_kati.sv
// ============================================================================
// Module      : sifreleme_boru_kati
// Description : Two-stage valid/ready wrapper around the combinational crypto
//               unit; optional delivered-op counter under SIFRELEME_SAYAC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sifreleme_boru_kati
  import sifreleme_boru_kati_pkg::*;
#(
  parameter int VERI_BIT  = 32,
  parameter int HEDEF_BIT = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 bosalt_i,
  input  logic                 istek_gecerli_i,
  output logic                 istek_hazir_o,
  input  kontrol_t             kontrol_i,
  input  logic [VERI_BIT-1:0]  deger1_i,
  input  logic [VERI_BIT-1:0]  deger2_i,
  input  logic [HEDEF_BIT-1:0] hedef_i,
  output kontrol_t             birim_kontrol_o,
  output logic [VERI_BIT-1:0]  birim_deger1_o,
  output logic [VERI_BIT-1:0]  birim_deger2_o,
  input  logic [VERI_BIT-1:0]  birim_sonuc_i,
  output logic                 sonuc_gecerli_o,
  input  logic                 sonuc_hazir_i,
  output logic [VERI_BIT-1:0]  sonuc_o,
  output logic [HEDEF_BIT-1:0] sonuc_hedef_o
`ifdef SIFRELEME_SAYAC_EN
  ,
  output logic [SAYAC_BIT-1:0] islem_sayisi_o
`endif
);

  localparam int S1_BIT = KONTROL_BIT + 2 * VERI_BIT + HEDEF_BIT;
  localparam int S2_BIT = VERI_BIT + HEDEF_BIT;

  logic                 s1_gecerli, s2_gecerli;
  logic                 s2_bos, s1_ilerle, istek_kabul;
  logic                 s1_yukle, s1_temizle, s2_yukle, s2_temizle;
  logic [S1_BIT-1:0]    s1_veri;
  logic [S2_BIT-1:0]    s2_veri;
  logic [HEDEF_BIT-1:0] s1_hedef;

  always_comb begin
    s2_bos        = !s2_gecerli || sonuc_hazir_i;
    s1_ilerle     = s1_gecerli && s2_bos;
    istek_hazir_o = (!s1_gecerli || s2_bos) && !bosalt_i;
    istek_kabul   = istek_gecerli_i && istek_hazir_o;

    // Flush suppresses the S1->S2 move so a killed op never reaches writeback.
    s1_yukle   = istek_kabul;
    s1_temizle = s1_ilerle || bosalt_i;
    s2_yukle   = s1_ilerle && !bosalt_i;
    s2_temizle = bosalt_i || (s2_gecerli && sonuc_hazir_i);
  end

  boru_yazmaci #(
    .GENISLIK (S1_BIT)
  ) u_s1 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .yukle_i   (s1_yukle),
    .temizle_i (s1_temizle),
    .veri_i    ({kontrol_i, deger1_i, deger2_i, hedef_i}),
    .gecerli_o (s1_gecerli),
    .veri_o    (s1_veri)
  );

  assign {birim_kontrol_o, birim_deger1_o, birim_deger2_o, s1_hedef} = s1_veri;

  boru_yazmaci #(
    .GENISLIK (S2_BIT)
  ) u_s2 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .yukle_i   (s2_yukle),
    .temizle_i (s2_temizle),
    .veri_i    ({birim_sonuc_i, s1_hedef}),
    .gecerli_o (s2_gecerli),
    .veri_o    (s2_veri)
  );

  assign {sonuc_o, sonuc_hedef_o} = s2_veri;
  assign sonuc_gecerli_o          = s2_gecerli;

`ifdef SIFRELEME_SAYAC_EN
  logic                 sonuc_teslim;
  logic [SAYAC_BIT-1:0] sayac_q, sayac_d;

  // Counts deliveries regardless of flush; wraps naturally at all-ones.
  always_comb begin
    sonuc_teslim = s2_gecerli && sonuc_hazir_i;
    sayac_d      = sonuc_teslim ? sayac_sonraki(sayac_q) : sayac_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sayac_q <= '0;
    end else begin
      sayac_q <= sayac_d;
    end
  end

  assign islem_sayisi_o = sayac_q;
`endif

endmodule

`default_nettype wire
